disp_scan_mux: RTL and testbench
================================

# disp_scan_mux

Parametrised, time-multiplexed digit scanner for the stopwatch display path. It takes a packed vector of BCD digits from the counter chain and presents one 4-bit code at a time on `outc`, with a matching one-hot digit-select, for the seven-segment decoder. It generalises the fixed 8-position chooser with:
- configurable digit count and scan rate;
- per-position separator insertion;
- leading-zero blanking;
- frame-coherent snapshotting and a freeze mode.

## Interface
Parameters:
- NUM_DIGITS, 8, number of scanned positions (2..16)
- SCAN_DIV, 1, clkc cycles per scan step (1..65535)
- SEP_CODE, 4'd10, code driven at separator positions
- BLANK_CODE, 4'd15, code the decoder renders as all segments off

Ports:
- clkc  in  1  clock; all logic on posedge clkc
- rst_n  in  1  reset, synchronous, active-low
- digits_in  in  4*NUM_DIGITS  packed BCD; position p = bits [4p+3:4p]; position NUM_DIGITS-1 is most significant
- sep_mask  in  NUM_DIGITS  bit p=1: position p shows SEP_CODE, its digit is ignored
- lz_blank_en  in  1  enable leading-zero blanking
- freeze  in  1  hold the current snapshot; scanning continues
- outc  out  4  code for the currently selected position (registered)
- dig_sel  out  NUM_DIGITS  one-hot, active-high select of the displayed position (registered)
- frame_start  out  1  one-cycle pulse when the MSB position is presented

## Operation
- Divider `div_cnt` counts 0..SCAN_DIV-1 and wraps. `tick` = (div_cnt == SCAN_DIV-1). With SCAN_DIV=1, tick is asserted every cycle.
- Index `idx` starts at NUM_DIGITS-1. On each tick it decrements, and wraps from 0 back to NUM_DIGITS-1.
- Frame source `src`:
  - At a tick with idx == NUM_DIGITS-1 and freeze=0: `snap <= digits_in`, and `src` = digits_in (bypass, so the first digit of the frame uses the new value).
  - At all other ticks, or when freeze=1: `src` = snap.
- sep_mask and lz_blank_en are sampled live at each tick; they are not snapshotted.
- Leading-zero rule. Position p is blank when all of the following hold:
  - lz_blank_en=1;
  - p != 0 (position 0 is never blanked);
  - every non-separator position q >= p in `src` holds 4'd0.
- A separator position is blanked when every non-separator position above it is zero.
- Output code at a tick, in priority order:
  1. blank → BLANK_CODE;
  2. else sep_mask[idx] → SEP_CODE;
  3. else digit idx of `src`.
- Non-BCD digit values (10..15) pass through unchanged and count as nonzero.
- `dig_sel <= 1 << idx` on each tick. `frame_start` = 1 for exactly one cycle when the newly loaded idx is NUM_DIGITS-1, else 0.

## Timing
- Reset (rst_n=0 at a clock edge) sets: outc=BLANK_CODE, dig_sel=0, frame_start=0, snap=0, div_cnt=0, idx=NUM_DIGITS-1.
- Reset takes priority over every other input. A reset mid-frame restarts the scan at the MSB position.
- First tick after reset release: cycle SCAN_DIV after the first edge with rst_n=1. outc and dig_sel update in that same edge, so latency from tick to output is 0 extra cycles.
- Each position is held for exactly SCAN_DIV cycles. A full frame lasts NUM_DIGITS*SCAN_DIV cycles.
- Between ticks, outc and dig_sel are stable; a change on digits_in does not affect them.
- Changes to digits_in mid-frame take effect at the next frame start, never within a frame.
- freeze sampled 1 at the frame-start tick: snap is kept and the whole frame is drawn from the old snap. Releasing freeze takes effect at the next frame start.
- dig_sel is always one-hot after the first tick. There are no idle gaps between positions.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, with NUM_DIGITS=8 and SCAN_DIV=1 → outc=4'hF, dig_sel=8'h00, frame_start=0. The first output after release is position 7 with frame_start=1.
- Basic scan: digits_in=32'h12345678, sep_mask=8'b00100100 (separators at positions 2 and 5), lz off, SCAN_DIV=1:
  - Expected outc sequence: 1,2,A,4,5,A,7,8, repeating.
  - Expected dig_sel: 80,40,...,01.
  - frame_start pulses once every 8 cycles.
- Leading-zero blanking: digits_in=32'h00000705, sep_mask=0, lz_blank_en=1 → outc sequence F,F,F,F,F,7,0,5. With digits_in=0, the sequence is F×7 followed by 0.
- Coherence and freeze:
  - Change digits_in from 32'h11111111 to 32'h22222222 while position 3 is shown → the rest of the frame shows 1s, and the next frame shows 2s.
  - With freeze=1 across a frame start → 1s persist until freeze=0 is seen at a later frame start.
- Divider: SCAN_DIV=4 → each dig_sel value holds for 4 cycles, and frame_start recurs every 32 cycles.
- Reset mid-operation: assert rst_n=0 for one cycle while position 2 is displayed → outputs return to their reset values, and the scan restarts at position 7 SCAN_DIV cycles after release.

Source files
------------

// File: rtl/disp_scan_mux.sv
// Time-multiplexed BCD digit scanner feeding the seven-segment decoder.
// Presents one code per scan step with matching one-hot select; frames are snapshot-coherent.
module disp_scan_mux #(
    parameter int          NUM_DIGITS = 8,
    parameter int          SCAN_DIV   = 1,
    parameter logic [3:0]  SEP_CODE   = 4'd10,
    parameter logic [3:0]  BLANK_CODE = 4'd15
) (
    input  logic                      clkc,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     sep_mask,
    input  logic                      lz_blank_en,
    input  logic                      freeze,
    output logic [3:0]                outc,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_start
);

    localparam logic [3:0]            IDX_MSB  = 4'(NUM_DIGITS - 1);
    localparam logic [15:0]           DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

    logic [15:0]             div_cnt;
    logic [3:0]              idx;
    logic [4*NUM_DIGITS-1:0] snap;
    logic [4*NUM_DIGITS-1:0] src;
    logic                    tick;
    logic                    frame_load;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic                    above_zero;
    logic [3:0]              cur_digit;
    logic                    cur_sep;
    logic                    cur_zero;
    logic                    blank;
    logic [3:0]              code;

    assign tick       = (div_cnt == DIV_LAST);
    assign frame_load = tick && (idx == IDX_MSB) && !freeze;

    // The first position of a frame bypasses the snapshot so it shows the value being captured.
    assign src = frame_load ? digits_in : snap;

    // zero_from[p]: every non-separator position at or above p is zero.
    always_comb begin
        zero_from  = '0;
        above_zero = 1'b1;
        for (int p = NUM_DIGITS - 1; p >= 0; p--) begin
            above_zero   = above_zero && (sep_mask[p] || (src[4*p +: 4] == 4'd0));
            zero_from[p] = above_zero;
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_sep   = 1'b0;
        cur_zero  = 1'b0;
        for (int p = 0; p < NUM_DIGITS; p++) begin
            if (idx == 4'(p)) begin
                cur_digit = src[4*p +: 4];
                cur_sep   = sep_mask[p];
                cur_zero  = zero_from[p];
            end
        end
        blank = lz_blank_en && (idx != 4'd0) && cur_zero;
        if (blank)
            code = BLANK_CODE;
        else if (cur_sep)
            code = SEP_CODE;
        else
            code = cur_digit;
    end

    always_ff @(posedge clkc) begin
        if (!rst_n) begin
            div_cnt     <= 16'd0;
            idx         <= IDX_MSB;
            snap        <= '0;
            outc        <= BLANK_CODE;
            dig_sel     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (tick) begin
                div_cnt     <= 16'd0;
                outc        <= code;
                dig_sel     <= SEL_ONE << idx;
                frame_start <= (idx == IDX_MSB);
                idx         <= (idx == 4'd0) ? IDX_MSB : idx - 4'd1;
                if (frame_load)
                    snap <= digits_in;
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench for disp_scan_mux: a fast instance (SCAN_DIV=1) checked against a scoreboard
// and a slow instance (SCAN_DIV=4) checked for hold time and frame recurrence.
module tb_disp_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [31:0] digits_in;
    logic [7:0]  sep_mask;
    logic        lz_blank_en;
    logic        freeze;
    logic [3:0]  outc1, outc4;
    logic [7:0]  dig_sel1, dig_sel4;
    logic        fs1, fs4;

    int total = 0;
    int bad   = 0;
    logic [12:0] sb[$];

    disp_scan_mux #(.NUM_DIGITS(8), .SCAN_DIV(1)) u_dut1 (
        .clkc(clk), .rst_n(rst_n), .digits_in(digits_in), .sep_mask(sep_mask),
        .lz_blank_en(lz_blank_en), .freeze(freeze),
        .outc(outc1), .dig_sel(dig_sel1), .frame_start(fs1)
    );

    disp_scan_mux #(.NUM_DIGITS(8), .SCAN_DIV(4)) u_dut4 (
        .clkc(clk), .rst_n(rst_n), .digits_in(digits_in), .sep_mask(sep_mask),
        .lz_blank_en(lz_blank_en), .freeze(freeze),
        .outc(outc4), .dig_sel(dig_sel4), .frame_start(fs4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_code(logic [31:0] d, logic [7:0] s, logic lz, int p);
        logic seen_nz;
        seen_nz = 1'b0;
        for (int q = 7; q >= p; q--)
            if (!s[q] && d[4*q +: 4] != 4'd0) seen_nz = 1'b1;
        if (lz && p != 0 && !seen_nz) return 4'hF;
        if (s[p]) return 4'hA;
        return d[4*p +: 4];
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected frame (or its first n positions) for the fast instance.
    task automatic push_frame(logic [31:0] d, logic [7:0] s, logic lz, int n);
        for (int k = 0; k < n; k++) begin
            int p;
            p = 7 - k;
            sb.push_back({(p == 7), 8'(1 << p), exp_code(d, s, lz, p)});
        end
    endtask

    task automatic run_check(int n);
        logic [12:0] e;
        repeat (n) begin
            @(posedge clk); #1;
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL sb_empty observed=0 expected=entry");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("outc1", 16'(outc1), 16'(e[3:0]));
                chk("dig_sel1", 16'(dig_sel1), 16'(e[11:4]));
                chk("frame_start1", 16'(fs1), 16'(e[12]));
            end
        end
    endtask

    task automatic set_in(logic [31:0] d, logic [7:0] s, logic lz);
        digits_in   = d;
        sep_mask    = s;
        lz_blank_en = lz;
    endtask

    initial begin
        rst_n  = 1'b0;
        freeze = 1'b0;
        set_in(32'h0, 8'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outc1", 16'(outc1), 16'hF);
        chk("rst_dig_sel1", 16'(dig_sel1), 16'h00);
        chk("rst_fs1", 16'(fs1), 16'h0);
        chk("rst_dig_sel4", 16'(dig_sel4), 16'h00);

        // Basic scan with separators at positions 2 and 5
        set_in(32'h12345678, 8'b0010_0100, 1'b0);
        rst_n = 1'b1;
        push_frame(digits_in, sep_mask, lz_blank_en, 8);
        push_frame(digits_in, sep_mask, lz_blank_en, 8);
        run_check(16);

        // Leading-zero blanking
        set_in(32'h00000705, 8'h00, 1'b1);
        push_frame(digits_in, sep_mask, lz_blank_en, 8);
        run_check(8);
        set_in(32'h00000000, 8'h00, 1'b1);
        push_frame(digits_in, sep_mask, lz_blank_en, 8);
        run_check(8);
        set_in(32'h00000012, 8'b0000_0100, 1'b1);
        push_frame(digits_in, sep_mask, lz_blank_en, 8);
        run_check(8);
        set_in(32'hF0A00003, 8'h00, 1'b1);
        push_frame(digits_in, sep_mask, lz_blank_en, 8);
        run_check(8);

        // Mid-frame change is deferred to the next frame
        set_in(32'h11111111, 8'h00, 1'b0);
        push_frame(32'h11111111, 8'h00, 1'b0, 8);
        push_frame(32'h11111111, 8'h00, 1'b0, 8);
        run_check(8);
        run_check(5);
        digits_in = 32'h22222222;
        run_check(3);
        push_frame(32'h22222222, 8'h00, 1'b0, 8);
        run_check(8);

        // Freeze across frame starts
        digits_in = 32'h11111111;
        push_frame(32'h11111111, 8'h00, 1'b0, 8);
        run_check(8);
        freeze    = 1'b1;
        digits_in = 32'h22222222;
        push_frame(32'h11111111, 8'h00, 1'b0, 8);
        push_frame(32'h11111111, 8'h00, 1'b0, 8);
        run_check(8);
        run_check(4);
        freeze = 1'b0;
        run_check(4);
        push_frame(32'h22222222, 8'h00, 1'b0, 8);
        run_check(8);

        // Reset while position 2 is shown
        set_in(32'h12345678, 8'h00, 1'b0);
        push_frame(digits_in, sep_mask, lz_blank_en, 6);
        run_check(6);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_outc1", 16'(outc1), 16'hF);
        chk("mid_rst_dig_sel1", 16'(dig_sel1), 16'h00);
        chk("mid_rst_fs1", 16'(fs1), 16'h0);
        chk("mid_rst_outc4", 16'(outc4), 16'hF);
        chk("mid_rst_dig_sel4", 16'(dig_sel4), 16'h00);
        rst_n = 1'b1;

        // Both instances restart; slow one holds each position for 4 cycles
        for (int f = 0; f < 5; f++) push_frame(digits_in, sep_mask, lz_blank_en, 8);
        for (int e = 1; e <= 40; e++) begin
            int pos;
            run_check(1);
            if (e < 4) begin
                chk("div_pre_dig_sel4", 16'(dig_sel4), 16'h00);
                chk("div_pre_outc4", 16'(outc4), 16'hF);
                chk("div_pre_fs4", 16'(fs4), 16'h0);
            end else begin
                pos = 7 - (((e - 4) / 4) % 8);
                chk("div_dig_sel4", 16'(dig_sel4), 16'(1 << pos));
                chk("div_outc4", 16'(outc4), 16'(digits_in[4*pos +: 4]));
                chk("div_fs4", 16'(fs4), 16'(((e - 4) % 32) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
